regfile_32x64: RTL and testbench



---
 rtl/regfile_pkg.sv | 9 +
 rtl/reg64_en.sv | 17 +
 rtl/regfile_dec.sv | 10 +
 rtl/regfile_mux.sv | 10 +
 rtl/regfile_32x64.sv | 40 ++++
 tb/tb_regfile_32x64.sv | 158 +++++++++++++++
 6 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and types for the 32x64 integer register file.
package regfile_pkg;
   localparam int XLEN = 64;
   localparam int NREGS = 32;
   localparam int AW = 5;
   localparam logic [AW-1:0] ZERO_REG = 5'd31;
   typedef logic [XLEN-1:0] word_t;
   typedef word_t [NREGS-1:0] regs_t;
endpackage

// File: rtl/reg64_en.sv
// reg64_en: 64-bit falling-edge register with load enable and async active-low clear.
module reg64_en
   import regfile_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  en_i,
   input  word_t d_i,
   output word_t q_o
);
   word_t data_q, data_d;
   assign data_d = en_i ? d_i : data_q;
   always_ff @(negedge clk_i or negedge rst_ni)
      if (!rst_ni) data_q <= '0;
      else data_q <= data_d;
   assign q_o = data_q;
endmodule

// File: rtl/regfile_dec.sv
// regfile_dec: 5-to-32 one-hot write decoder; all outputs low when disabled.
module regfile_dec
   import regfile_pkg::*;
(
   input  logic              en_i,
   input  logic [AW-1:0]     sel_i,
   output logic [NREGS-1:0]  onehot_o
);
   assign onehot_o = {{(NREGS-1){1'b0}}, en_i} << sel_i;
endmodule

// File: rtl/regfile_mux.sv
// regfile_mux: combinational 32:1 mux of 64-bit words.
module regfile_mux
   import regfile_pkg::*;
(
   input  regs_t         data_i,
   input  logic [AW-1:0] sel_i,
   output word_t         data_o
);
   assign data_o = data_i[sel_i];
endmodule

// File: rtl/regfile_32x64.sv
// regfile_32x64: 31 falling-edge storage registers plus hard-wired XZR,
// two combinational read ports and a flattened debug view.
module regfile_32x64
   import regfile_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] ReadRegister1,
   input  logic [AW-1:0] ReadRegister2,
   input  logic [AW-1:0] WriteRegister,
   input  word_t         WriteData,
   input  logic          RegWrite,
   output word_t         ReadData1,
   output word_t         ReadData2,
   output regs_t         out
);
   logic [NREGS-1:0] wr_en;
   regs_t            regs;
   logic             unused_en;

   regfile_dec u_dec (.en_i(RegWrite), .sel_i(WriteRegister), .onehot_o(wr_en));

   for (genvar i = 0; i < NREGS - 1; i++) begin : g_x
      reg64_en u_reg (
         .clk_i (clk),
         .rst_ni(rst),
         .en_i  (wr_en[i]),
         .d_i   (WriteData),
         .q_o   (regs[i])
      );
   end

   // XZR has no storage, so its decoder enable is intentionally dropped.
   assign regs[ZERO_REG] = '0;
   assign unused_en = wr_en[ZERO_REG];
   assign out = regs;

   regfile_mux u_rd1 (.data_i(regs), .sel_i(ReadRegister1), .data_o(ReadData1));
   regfile_mux u_rd2 (.data_i(regs), .sel_i(ReadRegister2), .data_o(ReadData2));
endmodule

// File: tb/tb_regfile_32x64.sv
// tb_regfile_32x64: directed scoreboard bench for the falling-edge register file.
module tb_regfile_32x64;
   import regfile_pkg::*;

   logic          clk, rst, RegWrite;
   logic [AW-1:0] ReadRegister1, ReadRegister2, WriteRegister;
   word_t         WriteData, ReadData1, ReadData2;
   regs_t         out;

   regfile_32x64 dut (
      .clk(clk), .rst(rst),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .out(out)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   typedef struct {
      string tag;
      word_t exp;
   } exp_t;

   exp_t  sbq[$];
   word_t model[NREGS];
   int    n_pass = 0;
   int    n_chk = 0;

   task automatic push(input string tag, input word_t exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sbq.push_back(e);
   endtask

   task automatic chk(input word_t obs);
      exp_t e;
      e = sbq.pop_front();
      n_chk++;
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
   endtask

   function automatic word_t exp_rd(input logic [AW-1:0] a);
      return (a == ZERO_REG) ? '0 : model[a];
   endfunction

   task automatic rd(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      ReadRegister1 = a1;
      ReadRegister2 = a2;
      push($sformatf("%s rd1 X%0d", tag, a1), exp_rd(a1));
      push($sformatf("%s rd2 X%0d", tag, a2), exp_rd(a2));
      #1;
      chk(ReadData1);
      chk(ReadData2);
   endtask

   task automatic chk_all(input string tag);
      for (int j = 0; j < NREGS; j++) push($sformatf("%s out[%0d]", tag, j), exp_rd(j[AW-1:0]));
      for (int j = 0; j < NREGS; j++) chk(out[j]);
   endtask

   task automatic wr(input logic [AW-1:0] a, input word_t d, input logic we);
      @(posedge clk);
      #1;
      WriteRegister = a;
      WriteData = d;
      RegWrite = we;
      @(negedge clk);
      #1;
      RegWrite = 1'b0;
      if (we && a != ZERO_REG) model[a] = d;
   endtask

   initial begin
      rst = 1'b0;
      RegWrite = 1'b0;
      WriteRegister = '0;
      WriteData = '0;
      ReadRegister1 = '0;
      ReadRegister2 = '0;
      for (int j = 0; j < NREGS; j++) model[j] = '0;
      #1;
      chk_all("por");
      rd("por", 5'd0, 5'd31);
      rst = 1'b1;

      wr(5'd5, 64'hDEADBEEF_CAFEF00D, 1'b1);
      rd("w5", 5'd5, 5'd4);
      push("w5 out[5]", 64'hDEADBEEF_CAFEF00D);
      chk(out[5]);

      wr(5'd7, 64'h1234, 1'b0);
      push("nowe X7", 64'h0);
      chk(out[7]);
      rd("nowe", 5'd7, 5'd5);

      wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      rd("xzr", 5'd31, 5'd31);
      push("xzr out[31]", 64'h0);
      chk(out[31]);
      chk_all("xzr");

      for (int i = 0; i < NREGS - 1; i++) wr(i[AW-1:0], 64'(i) * 64'h0101_0101_0101_0101, 1'b1);
      for (int i = 0; i < NREGS - 1; i++) rd("sweep", i[AW-1:0], 5'(30 - i));
      chk_all("sweep");

      // Write and read X10 within one clock high-low period.
      @(posedge clk);
      #1;
      WriteRegister = 5'd10;
      WriteData = 64'hA5A5;
      RegWrite = 1'b1;
      ReadRegister1 = 5'd31;
      ReadRegister2 = 5'd10;
      push("same before", 64'h0A0A_0A0A_0A0A_0A0A);
      #1;
      chk(ReadData2);
      @(negedge clk);
      #1;
      model[10] = 64'hA5A5;
      push("same after", 64'hA5A5);
      chk(ReadData2);
      RegWrite = 1'b0;
      chk_all("same");

      // Async reset asserted mid-high with a write pending, then released while clk is low.
      @(posedge clk);
      #1;
      WriteRegister = 5'd4;
      WriteData = 64'h0BAD_F00D_1234_5678;
      RegWrite = 1'b1;
      #1;
      rst = 1'b0;
      for (int j = 0; j < NREGS; j++) model[j] = '0;
      #1;
      chk_all("rst async");
      rd("rst async", 5'd4, 5'd30);
      @(negedge clk);
      #1;
      chk_all("rst hold");
      #1;
      rst = 1'b1;
      #1;
      push("rst rel X4", 64'h0);
      chk(out[4]);
      @(negedge clk);
      #1;
      RegWrite = 1'b0;
      model[4] = 64'h0BAD_F00D_1234_5678;
      chk_all("rst first wr");
      rd("rst first wr", 5'd4, 5'd4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
